// File: rtl/player_input_ctrl_if.sv
// Player input bundle: raw pushbuttons in, movement/jump requests out.
// The slave modport is the controller side; the master modport is the
// side that owns the buttons and consumes the requests.
interface player_input_ctrl_if;
    logic btn_left;
    logic btn_right;
    logic btn_jump;
    logic movingLeft;
    logic movingRight;
    logic isJumping;
    logic jump_ready;

    modport master (
        output btn_left,
        output btn_right,
        output btn_jump,
        input  movingLeft,
        input  movingRight,
        input  isJumping,
        input  jump_ready
    );

    modport slave (
        input  btn_left,
        input  btn_right,
        input  btn_jump,
        output movingLeft,
        output movingRight,
        output isJumping,
        output jump_ready
    );
endinterface

// File: rtl/player_input_ctrl.sv
// Player input controller: synchronizes and debounces three pushbuttons,
// resolves left/right into exclusive movement requests and turns the jump
// button into a single fixed-length pulse followed by a cooldown.
// Optional feature macro: PLAYER_INPUT_LASTPRESS_EN -- when defined, the most
// recently pressed direction wins while both are held; otherwise holding
// both directions cancels movement.
module player_input_ctrl #(
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int JUMP_HOLD_CYCLES     = 5000000,
    parameter int JUMP_COOLDOWN_CYCLES = 10000000
) (
    input  logic                 clk,
    input  logic                 reset,
    player_input_ctrl_if.slave   bus
);

    // A zero-length parameter would make the terminal count underflow, so
    // every timing parameter is clamped to at least one cycle.
    localparam int DEB_EFF   = (DEBOUNCE_CYCLES      < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int HOLD_EFF  = (JUMP_HOLD_CYCLES     < 1) ? 1 : JUMP_HOLD_CYCLES;
    localparam int COOL_EFF  = (JUMP_COOLDOWN_CYCLES < 1) ? 1 : JUMP_COOLDOWN_CYCLES;
    localparam int PHASE_MAX = (HOLD_EFF > COOL_EFF) ? HOLD_EFF : COOL_EFF;

    localparam int DEB_W   = $clog2(DEB_EFF + 1);
    localparam int PHASE_W = $clog2(PHASE_MAX + 1);

    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_EFF - 1);
    localparam logic [PHASE_W-1:0] HOLD_LAST = PHASE_W'(HOLD_EFF - 1);
    localparam logic [PHASE_W-1:0] COOL_LAST = PHASE_W'(COOL_EFF - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        COOLDOWN,
        WAIT_RELEASE
    } jump_state_t;

    // Bit 0 = left, bit 1 = right, bit 2 = jump throughout.
    logic [2:0]       raw;
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [2:0]       deb;
    logic [DEB_W-1:0] deb_cnt [3];

    logic [1:0] move_res;
    logic [1:0] move_q;
    logic       moving_left_q;
    logic       moving_right_q;

    jump_state_t        state;
    jump_state_t        next_state;
    logic [PHASE_W-1:0] phase_cnt;
    logic [PHASE_W-1:0] next_phase_cnt;
    logic               jump_prev;
    logic               jump_rise;
    logic               is_jumping_q;
    logic               jump_ready_q;

    assign raw = {bus.btn_jump, bus.btn_right, bus.btn_left};

    // Two-flop synchronizer in front of everything else for the async buttons.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Per-button debounce: count consecutive disagreeing cycles and flip the
    // debounced level when the count would reach the threshold, so it never wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            deb <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

`ifdef PLAYER_INPUT_LASTPRESS_EN
    logic [1:0] move_prev;
    logic       last_right;
    logic       last_sel;

    // Track which direction was pressed most recently; a fresh press on the
    // current cycle takes effect immediately, right wins a tie.
    always_comb begin
        last_sel = last_right;
        if (deb[1] && !move_prev[1]) begin
            last_sel = 1'b1;
        end else if (deb[0] && !move_prev[0]) begin
            last_sel = 1'b0;
        end
        move_res[0] = deb[0] & (~deb[1] | ~last_sel);
        move_res[1] = deb[1] & (~deb[0] |  last_sel);
    end

    // Remember previous debounced direction levels and the winning direction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            move_prev  <= '0;
            last_right <= 1'b0;
        end else begin
            move_prev  <= deb[1:0];
            last_right <= last_sel;
        end
    end
`else
    // Holding both directions cancels movement entirely.
    always_comb begin
        move_res[0] = deb[0] & ~deb[1];
        move_res[1] = deb[1] & ~deb[0];
    end
`endif

    // Movement path: resolve stage then output register; both stages see
    // exclusive values so the outputs can never be high together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            move_q         <= '0;
            moving_left_q  <= 1'b0;
            moving_right_q <= 1'b0;
        end else begin
            move_q         <= move_res;
            moving_left_q  <= move_q[0];
            moving_right_q <= move_q[1];
        end
    end

    assign jump_rise = deb[2] & ~jump_prev;

    // Jump FSM next-state: edges outside IDLE are simply dropped, and a held
    // button parks the FSM in WAIT_RELEASE instead of repeating.
    always_comb begin
        next_state     = state;
        next_phase_cnt = '0;
        case (state)
            IDLE: begin
                if (jump_rise) begin
                    next_state = PULSE;
                end
            end
            PULSE: begin
                if (phase_cnt == HOLD_LAST) begin
                    next_state = COOLDOWN;
                end else begin
                    next_phase_cnt = phase_cnt + PHASE_W'(1);
                end
            end
            COOLDOWN: begin
                if (phase_cnt == COOL_LAST) begin
                    next_state = WAIT_RELEASE;
                end else begin
                    next_phase_cnt = phase_cnt + PHASE_W'(1);
                end
            end
            WAIT_RELEASE: begin
                if (!deb[2]) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Jump FSM state register plus registered pulse and ready flags, which
    // follow the state one edge later; reset drops the pulse immediately.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            jump_prev    <= 1'b0;
            is_jumping_q <= 1'b0;
            jump_ready_q <= 1'b1;
        end else begin
            state        <= next_state;
            phase_cnt    <= next_phase_cnt;
            jump_prev    <= deb[2];
            is_jumping_q <= (state == PULSE);
            jump_ready_q <= (state == IDLE);
        end
    end

    assign bus.movingLeft  = moving_left_q;
    assign bus.movingRight = moving_right_q;
    assign bus.isJumping   = is_jumping_q;
    assign bus.jump_ready  = jump_ready_q;

endmodule

// File: doc/player_input_ctrl.md
PLAYER_INPUT_CTRL -- requirements
Module: player_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive clk cycles a synchronized button must disagree with its debounced state before that state flips (10 ms at 100 MHz).
REQ-002 Parameter JUMP_HOLD_CYCLES, default 5000000: length of the isJumping pulse, one full 20 Hz physics tick.
REQ-003 Parameter JUMP_COOLDOWN_CYCLES, default 10000000: minimum gap after a jump pulse ends before a new jump is accepted.
REQ-004 clk  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-006 btn_left, btn_right, btn_jump  input  1 each  raw asynchronous pushbuttons, active-high.
REQ-007 movingLeft, movingRight  output  1 each  registered level requests to the physics stage.
REQ-008 isJumping  output  1  registered jump request pulse to the physics stage.
REQ-009 jump_ready  output  1  registered; high only in jump state IDLE.

Function
REQ-010 Each btn_* SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button SHALL have an independent debounce counter, at least clog2(DEBOUNCE_CYCLES+1) bits, cleared on any cycle where synchronized input equals debounced state.
REQ-012 Debounced state SHALL flip, and its counter clear, on the edge where the counter would reach DEBOUNCE_CYCLES; the counter SHALL never wrap.
REQ-013 Latency: with a raw button held stable, movingLeft/movingRight SHALL change exactly DEBOUNCE_CYCLES+3 clk edges after the first edge sampling the new raw level; same for press and release.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES cycles (post-sync) SHALL produce no output change.
REQ-015 movingLeft = debounced left AND NOT suppressed; movingRight likewise; both outputs SHALL never be high together.
REQ-016 Jump FSM states: IDLE, PULSE, COOLDOWN, WAIT_RELEASE.
REQ-017 IDLE -> PULSE on a debounced btn_jump rising edge; isJumping SHALL assert on the following edge.
REQ-018 PULSE holds isJumping=1 for exactly JUMP_HOLD_CYCLES cycles, then -> COOLDOWN with isJumping=0.
REQ-019 COOLDOWN lasts exactly JUMP_COOLDOWN_CYCLES cycles, then -> WAIT_RELEASE.
REQ-020 WAIT_RELEASE -> IDLE when debounced jump is 0 (same cycle if already released); holding jump SHALL never auto-repeat.
REQ-021 Jump edges arriving in PULSE, COOLDOWN or WAIT_RELEASE SHALL be ignored, not queued.
REQ-022 Jump FSM and move logic SHALL be independent; simultaneous move and jump presses both take effect.
REQ-023 Counters SHALL be sized from their parameters; a parameter of 0 SHALL be treated as 1.

Reset
REQ-024 While reset=0 at a clk edge: synchronizers, debounced states and counters cleared, FSM to IDLE, movingLeft=movingRight=isJumping=0, jump_ready=1 on the next edge.
REQ-025 Reset mid-PULSE SHALL drop isJumping on that same edge; a button held through reset release SHALL be treated as a fresh press after full debounce.

Configuration
REQ-026 Macro PLAYER_INPUT_LASTPRESS_EN defined: when both directions are debounced-pressed, the most recently pressed direction SHALL drive its output and the other is suppressed; on release of that one, the still-held direction resumes after 1 cycle.
REQ-027 Macro not defined: both directions debounced-pressed SHALL force movingLeft=movingRight=0.

Verification (DEBOUNCE_CYCLES=4, JUMP_HOLD_CYCLES=6, JUMP_COOLDOWN_CYCLES=8)
REQ-028 btn_left high from edge 0 held -> movingLeft rises at edge 7; released at edge 20 -> falls at edge 27.
REQ-029 btn_right 3-cycle glitch -> movingRight stays 0 throughout.
REQ-030 btn_jump pressed, held 40 cycles -> exactly one isJumping pulse of 6 cycles, jump_ready low until release debounced after cooldown.
REQ-031 Second jump press during COOLDOWN -> no pulse; press after return to IDLE -> new 6-cycle pulse.
REQ-032 Left held, then right pressed -> with PLAYER_INPUT_LASTPRESS_EN: movingRight=1, movingLeft=0; without: both 0.
REQ-033 reset=0 asserted 2 cycles into PULSE -> isJumping=0 on that edge, all outputs 0, jump_ready=1 next edge.
